// File: rtl/seqdet_pkg.sv
// Shared types and reset defaults for the programmable serial sequence detector.
// The config struct is sized to fixed capacities so any PAT_MAX up to SEQDET_PAT_CAP fits.
package seqdet_pkg;

  localparam int SEQDET_PAT_CAP   = 32;
  localparam int SEQDET_LEN_CAP_W = 6;

  localparam logic [2:0] SEQDET_DEF_PAT = 3'b101;
  localparam int         SEQDET_DEF_LEN = 3;

  typedef struct packed {
    logic [SEQDET_PAT_CAP-1:0]   pattern;
    logic [SEQDET_LEN_CAP_W-1:0] len;
    logic                        overlap;
  } seqdet_cfg_t;

  localparam seqdet_cfg_t SEQDET_CFG_RST = '{
    pattern: SEQDET_PAT_CAP'(SEQDET_DEF_PAT),
    len:     SEQDET_LEN_CAP_W'(SEQDET_DEF_LEN),
    overlap: 1'b1
  };

  function automatic logic seqdet_len_bad(input logic [SEQDET_LEN_CAP_W-1:0] len,
                                          input int pat_max);
    return (len == '0) || (int'(len) > pat_max);
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating match counter; a clear coinciding with an increment leaves a count of one.
module seqdet_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_d, count_q;
  logic             sat_d, sat_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && !sat_q) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = &count_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seqdet_onehot_param.sv
// Runtime-programmable serial sequence detector built on a prefix-match vector,
// with registered match pulse, one-hot progress and a saturating match counter.
module seqdet_onehot_param
  import seqdet_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [PAT_MAX-1:0] state_onehot,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               cfg_err
);

  seqdet_cfg_t        cfg_d, cfg_q;
  logic               cfg_err_d, cfg_err_q;
  logic [PAT_MAX-1:1] p_d, p_q, p_upd;
  logic [PAT_MAX-1:0] pfx, pat, state_d, state_q;
  logic               match_d, match_q, hit;
  int                 len_i;
  logic               unused_pat_hi;

  // pfx[k] is the prefix vector with the always-true empty prefix at bit 0.
  always_comb begin
    pat   = cfg_q.pattern[PAT_MAX-1:0];
    len_i = int'(cfg_q.len);
    pfx   = {p_q, 1'b1};
    p_upd = '0;
    hit   = 1'b0;
    for (int k = 1; k < PAT_MAX; k++) begin
      if (k < len_i) p_upd[k] = pfx[k-1] & (din == pat[k-1]);
    end
    for (int k = 0; k < PAT_MAX; k++) begin
      if (k == len_i - 1) hit = pfx[k] & (din == pat[k]);
    end
  end

  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    p_d       = p_q;
    match_d   = 1'b0;
    if (cfg_we) begin
      cfg_d.pattern = SEQDET_PAT_CAP'(cfg_pattern);
      cfg_d.len     = SEQDET_LEN_CAP_W'(cfg_len);
      cfg_d.overlap = cfg_overlap;
      cfg_err_d     = seqdet_len_bad(SEQDET_LEN_CAP_W'(cfg_len), PAT_MAX);
      p_d           = '0;
    end else if (din_valid && !cfg_err_q) begin
      match_d = hit;
      p_d     = (hit && !cfg_q.overlap) ? '0 : p_upd;
    end

    // Highest matched prefix wins; the empty prefix is the fallback.
    state_d    = '0;
    state_d[0] = 1'b1;
    for (int k = 1; k < PAT_MAX; k++) begin
      if (p_d[k]) begin
        state_d    = '0;
        state_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q     <= SEQDET_CFG_RST;
      cfg_err_q <= 1'b0;
      p_q       <= '0;
      match_q   <= 1'b0;
      state_q   <= PAT_MAX'(1);
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      p_q       <= p_d;
      match_q   <= match_d;
      state_q   <= state_d;
    end
  end

  seqdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .inc    (match_d),
    .count  (match_count),
    .sat    (count_sat)
  );

  // Pattern capacity above PAT_MAX is carried but never consulted.
  assign unused_pat_hi = ^cfg_q.pattern;

  assign match        = match_q;
  assign state_onehot = state_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: doc/seqdet_onehot_param.md
# seqdet_onehot_param

Parametrised, runtime-programmable serial sequence detector: the next generation of the team's fixed 4-state one-hot `101` FSM. The pattern, its length and the overlap mode are loaded through a config port instead of being hard-wired, and input is qualified by `din_valid`. The block emits a registered match pulse, the current progress as a one-hot state vector, and a saturating match counter. It sits on serial protocol front-ends, directly after the bit deserialiser.

## Interface
- `PAT_MAX`, default 8: maximum pattern length in bits, at least 2.
- `LEN_W`, default `$clog2(PAT_MAX+1)`: width of `cfg_len`.
- `CNT_W`, default 16: width of the match counter, at least 2.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  load `cfg_pattern`, `cfg_len` and `cfg_overlap` on this edge.
- `cfg_pattern`  in  PAT_MAX  pattern bits; bit 0 is the first bit received.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = history flushed after each match.
- `din_valid`  in  1  `din` is valid this cycle.
- `din`  in  1  serial data bit.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `match`  out  1  one-cycle registered pulse when a pattern completes.
- `state_onehot`  out  PAT_MAX  one-hot longest prefix currently matched; bit k set means k bits are matched.
- `match_count`  out  CNT_W  saturating count of matches.
- `count_sat`  out  1  `match_count` is all-ones.
- `cfg_err`  out  1  the loaded `cfg_len` is 0 or greater than `PAT_MAX`; the detector is disabled.

## Operation
- Internal prefix vector `p[PAT_MAX-1:1]`; `p[0]` is implicitly 1. `p[k]` means the last k valid bits equal `pattern[0..k-1]`. Several bits may be set at once.
- On a `din_valid` edge with L = active length, for k = 1..L-1: `p[k] <= p[k-1] & (din == pat[k-1])`. Bits at index L and above are held at 0.
- A match is `p[L-1] & (din == pat[L-1])`. On a match:
  - `match <= 1`.
  - If overlap is 0, all of `p` is cleared.
  - If overlap is 1, the normal update of `p` is kept.
- Without `din_valid`: `p` holds and `match <= 0`.
- `state_onehot` is the one-hot of the highest set index of `{p, 1}`; it is bit 0 when nothing is matched.
- `cfg_we`:
  - Latches the new config and clears `p`. `match` is 0 on that edge.
  - Any `din_valid` beat on the same edge is ignored.
  - Sets `cfg_err` when `cfg_len` is 0 or greater than `PAT_MAX`. While `cfg_err` is set, there are no matches and `p` stays 0.
- Counter:
  - Increments on every `match` and saturates at 2^CNT_W−1; it never wraps.
  - `cnt_clr` alone gives 0.
  - `cnt_clr` on the same edge as a new match gives 1.

## Timing
- Reset values: `match`=0, `state_onehot`=1 (bit 0), `match_count`=0, `count_sat`=0, `cfg_err`=0. Reset also clears `p` and sets the config to pattern 0b101, length 3, overlap 1, i.e. the legacy behaviour.
- Reset is asynchronous and takes effect mid-pattern; any partial match is lost.
- Latency: `match`, `state_onehot` and `match_count` update on the same edge that samples the final pattern bit, and are visible the following cycle.
- A new config takes effect for the first `din_valid` beat after the `cfg_we` edge.
- All outputs come directly from registers; there is no combinational input-to-output path.

## Structure
- Package `seqdet_pkg` holds:
  - The `seqdet_cfg_t` struct: pattern, length, overlap.
  - The reset-default constants (`SEQDET_DEF_PAT`=3'b101, `SEQDET_DEF_LEN`=3).
- Sub-module `seqdet_sat_counter` (parameter `CNT_W`) implements the counter with its clear/increment priority and `count_sat`.
- The top level holds the config register, the prefix vector and the priority-encode to `state_onehot`.

## Test plan
- Reset defaults, `din` stream 1,0,1,0,1 with valid every cycle → `match` pulses after beats 3 and 5; `match_count`=2; `state_onehot`=bit 1 after beat 5.
- Same stream with `cfg_overlap`=0 → exactly one pulse, after beat 3; `match_count`=1.
- Pattern 1101, length 4, with `din_valid` gaps of 1–3 idle cycles between bits → a single match; `p` and `state_onehot` hold through the gaps; no spurious `match`.
- Pattern 11 loaded after bits 1,1 of the old pattern, with `cfg_we` and `din_valid` asserted together → flush, beat ignored, `state_onehot`=1; the next bits 1,1 → match.
- `cfg_len`=0 and then 9 (with `PAT_MAX`=8) → `cfg_err`=1 and no matches on any stream; loading a legal length clears `cfg_err`.
- `CNT_W`=4 with 20 matches → `match_count`=15 and `count_sat`=1.
  - `cnt_clr` together with a match → 1.
  - `resetn` pulsed mid-pattern → all reset values restored immediately.
